// File: rtl/load_store_unit_if.sv
// Data-memory handshake between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: validates the access, runs one memory handshake with a
// bounded wait, formats load data and stalls the pipeline while busy.
//   state | meaning
//   IDLE  | waiting for MemRead/MemWrite; illegal accesses fault here
//   BUSY  | mem_req held, waiting for mem_ack or the timeout count
//   DONE  | one-cycle result slot, Stall released, request inputs ignored
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [31:0]       Addr,
  input  logic [31:0]       WrData,
  output logic [31:0]       ReadData,
  output logic              Stall,
  output logic              Fault,
  load_store_unit_if.master mem
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] read_data_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        we_q;
  logic        req_q;
  logic        fault_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;

  logic        access;
  logic        f3_ok;
  logic        aligned;
  logic        bad;
  logic        good;
  logic        in_idle;
  logic [31:0] wdata_d;
  logic [3:0]  wstrb_d;
  logic [31:0] load_d;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    access = MemRead | MemWrite;
    if (MemWrite)
      f3_ok = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010);
    else
      f3_ok = (Funct3 != 3'b011) && (Funct3 != 3'b110) && (Funct3 != 3'b111);
    case (Funct3[1:0])
      2'b01:   aligned = ~Addr[0];
      2'b10:   aligned = (Addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    bad  = access & ((MemRead & MemWrite) | ~f3_ok | ~aligned);
    good = access & ~bad;
  end

  // Stores replicate the datum across all lanes; the strobe picks the lane.
  always_comb begin
    wdata_d = WrData;
    wstrb_d = 4'b1111;
    case (Funct3[1:0])
      2'b00: begin
        wdata_d = {4{WrData[7:0]}};
        wstrb_d = 4'b0001 << Addr[1:0];
      end
      2'b01: begin
        wdata_d = {2{WrData[15:0]}};
        wstrb_d = Addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    sel_byte = mem.mem_rdata[{off_q, 3'b000} +: 8];
    sel_half = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_d = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_d = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_d = {24'd0, sel_byte};
      3'b101:  load_d = {16'd0, sel_half};
      default: load_d = mem.mem_rdata;
    endcase
  end

  assign in_idle       = (state_q == IDLE);
  assign Stall         = reset & ((in_idle & good) | (state_q == BUSY));
  assign Fault         = reset & ((in_idle & bad) | ((state_q == DONE) & fault_q));
  assign ReadData      = (in_idle & bad) ? 32'd0 : read_data_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wstrb = wstrb_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      read_data_q <= 32'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      we_q        <= 1'b0;
      req_q       <= 1'b0;
      fault_q     <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (good) begin
            addr_q   <= {Addr[31:2], 2'b00};
            we_q     <= MemWrite;
            wdata_q  <= MemWrite ? wdata_d : 32'd0;
            wstrb_q  <= MemWrite ? wstrb_d : 4'd0;
            funct3_q <= Funct3;
            off_q    <= Addr[1:0];
            cnt_q    <= 8'd0;
            req_q    <= 1'b1;
            state_q  <= BUSY;
          end else if (bad) begin
            read_data_q <= 32'd0;
          end
        end
        BUSY: begin
          if (mem.mem_ack) begin
            if (!we_q) read_data_q <= load_d;
            fault_q <= 1'b0;
            req_q   <= 1'b0;
            state_q <= DONE;
          end else if (cnt_q == LAST_CNT) begin
            read_data_q <= 32'd0;
            fault_q     <= 1'b1;
            req_q       <= 1'b0;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          fault_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// accesses checked against a byte-arithmetic reference model.
module tb_load_store_unit;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr, WrData;
  logic [31:0] ReadData;
  logic        Stall, Fault;

  int n_cmp = 0;
  int n_err = 0;

  int          ob_stall, ob_busy, ob_cycles;
  logic        ob_done, ob_fault, ob_we, ob_stable;
  logic [31:0] ob_rd, ob_addr, ob_wdata;
  logic [3:0]  ob_wstrb;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
  } acc_t;

  load_store_unit_if mif ();

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .reset    (reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Funct3   (Funct3),
    .Addr     (Addr),
    .WrData   (WrData),
    .ReadData (ReadData),
    .Stall    (Stall),
    .Fault    (Fault),
    .mem      (mif)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int m_bytes(input logic [2:0] f3);
    return 1 << int'(f3[1:0]);
  endfunction

  function automatic logic m_legal(input logic rd, input logic wr,
                                   input logic [2:0] f3, input logic [31:0] a);
    if (rd == wr) return 1'b0;
    if (wr && f3 > 3'd2) return 1'b0;
    if (rd && (f3 == 3'd3 || f3 >= 3'd6)) return 1'b0;
    return (a % m_bytes(f3)) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] w);
    longint v;
    int     n;
    n = m_bytes(f3);
    v = {32'd0, w};
    v = (v >> (8 * (a % 4))) & ((64'd1 << (8 * n)) - 1);
    if (f3 < 3'd4 && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
    if (m_bytes(f3) == 1) return (w & 32'hFF) * 32'h0101_0101;
    if (m_bytes(f3) == 2) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = ((1 << m_bytes(f3)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  // Drives one access and records what the DUT did; ack_at=0 withholds mem_ack.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdata, input int ack_at);
    ob_stall = 0; ob_busy = 0; ob_cycles = 0; ob_done = 0; ob_fault = 0; ob_stable = 1;
    ob_rd = '0; ob_addr = '0; ob_wdata = '0; ob_wstrb = '0; ob_we = 0;
    MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WrData = wd;
    mif.mem_rdata = rdata; mif.mem_ack = 1'b0;
    for (int c = 0; c < TIMEOUT + 6 && !ob_done; c++) begin
      @(negedge clk);
      ob_cycles++;
      if (Stall) ob_stall++;
      if (mif.mem_req) begin
        if (ob_busy == 0) begin
          ob_addr = mif.mem_addr; ob_wdata = mif.mem_wdata;
          ob_wstrb = mif.mem_wstrb; ob_we = mif.mem_we;
        end else if ({mif.mem_addr, mif.mem_wdata, mif.mem_wstrb, mif.mem_we} !==
                     {ob_addr, ob_wdata, ob_wstrb, ob_we}) begin
          ob_stable = 0;
        end
        ob_busy++;
        mif.mem_ack = (ob_busy == ack_at);
      end else if (c > 0 && !Stall) begin
        ob_done = 1; ob_rd = ReadData; ob_fault = Fault;
      end
      @(posedge clk); #1;
      mif.mem_ack = 1'b0;
    end
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; MemRead = 0; MemWrite = 0; Funct3 = 0; Addr = 0; WrData = 0;
    mif.mem_ack = 0; mif.mem_rdata = 0;
    repeat (2) @(negedge clk);
    n_cmp++; if (ReadData !== 32'd0) begin n_err++; $display("FAIL reset_readdata got %h want 0", ReadData); end
    n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", Stall); end
    n_cmp++; if (Fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got %b want 0", Fault); end
    n_cmp++; if (mif.mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", mif.mem_req); end
    n_cmp++; if ({mif.mem_we, mif.mem_wstrb, mif.mem_addr, mif.mem_wdata} !== '0) begin
      n_err++; $display("FAIL reset_bus we=%b wstrb=%b addr=%h wdata=%h want all 0",
                        mif.mem_we, mif.mem_wstrb, mif.mem_addr, mif.mem_wdata);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lb();
    do_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 1);
    n_cmp++; if (ob_done !== 1'b1) begin n_err++; $display("FAIL lb_done got %b want 1", ob_done); end
    n_cmp++; if (ob_rd !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_data got %h want ffffff80", ob_rd); end
    n_cmp++; if (ob_addr !== 32'h100) begin n_err++; $display("FAIL lb_addr got %h want 00000100", ob_addr); end
    n_cmp++; if (ob_stall != 2) begin n_err++; $display("FAIL lb_stall got %0d want 2", ob_stall); end
    n_cmp++; if ({ob_fault, ob_we} !== 2'b00) begin n_err++; $display("FAIL lb_fault_we got %b%b want 00", ob_fault, ob_we); end
  endtask

  task automatic test_sh();
    do_access(0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0, 3);
    n_cmp++; if (ob_wdata !== 32'hABCD_ABCD) begin n_err++; $display("FAIL sh_wdata got %h want abcdabcd", ob_wdata); end
    n_cmp++; if (ob_wstrb !== 4'b1100) begin n_err++; $display("FAIL sh_wstrb got %b want 1100", ob_wstrb); end
    n_cmp++; if (ob_we !== 1'b1) begin n_err++; $display("FAIL sh_we got %b want 1", ob_we); end
    n_cmp++; if (ob_stall != 4) begin n_err++; $display("FAIL sh_stall got %0d want 4", ob_stall); end
    n_cmp++; if (ob_stable !== 1'b1) begin n_err++; $display("FAIL sh_stable got %b want 1", ob_stable); end
    n_cmp++; if ({ob_done, ob_fault} !== 2'b10) begin n_err++; $display("FAIL sh_done_fault got %b%b want 10", ob_done, ob_fault); end
  endtask

  task automatic test_illegal();
    acc_t tbl [8];
    tbl[0] = '{1'b1, 1'b0, 3'b010, 32'h105};
    tbl[1] = '{1'b1, 1'b0, 3'b001, 32'h101};
    tbl[2] = '{1'b0, 1'b1, 3'b001, 32'h203};
    tbl[3] = '{1'b0, 1'b1, 3'b010, 32'h102};
    tbl[4] = '{1'b1, 1'b0, 3'b011, 32'h000};
    tbl[5] = '{1'b1, 1'b0, 3'b110, 32'h000};
    tbl[6] = '{1'b0, 1'b1, 3'b100, 32'h000};
    tbl[7] = '{1'b1, 1'b1, 3'b010, 32'h000};
    for (int i = 0; i < 8; i++) begin
      MemRead = tbl[i].rd; MemWrite = tbl[i].wr; Funct3 = tbl[i].f3; Addr = tbl[i].a;
      WrData = $urandom; mif.mem_ack = 1'b0;
      @(negedge clk);
      n_cmp++; if ({Fault, Stall} !== 2'b10) begin n_err++; $display("FAIL illegal%0d_fault_stall got %b%b want 10", i, Fault, Stall); end
      n_cmp++; if (ReadData !== 32'd0) begin n_err++; $display("FAIL illegal%0d_readdata got %h want 0", i, ReadData); end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if ({mif.mem_req, Stall} !== 2'b00) begin n_err++; $display("FAIL illegal%0d_noreq got req=%b stall=%b want 0 0", i, mif.mem_req, Stall); end
      @(posedge clk); #1;
    end
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic test_timeout();
    do_access(1, 0, 3'b101, 32'h0, 32'h0, 32'hDEAD_BEEF, 0);
    n_cmp++; if (ob_busy != TIMEOUT) begin n_err++; $display("FAIL to_busy got %0d want %0d", ob_busy, TIMEOUT); end
    n_cmp++; if (ob_stall != TIMEOUT + 1) begin n_err++; $display("FAIL to_stall got %0d want %0d", ob_stall, TIMEOUT + 1); end
    n_cmp++; if ({ob_done, ob_fault} !== 2'b11) begin n_err++; $display("FAIL to_done_fault got %b%b want 11", ob_done, ob_fault); end
    n_cmp++; if (ob_rd !== 32'd0) begin n_err++; $display("FAIL to_readdata got %h want 0", ob_rd); end
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] rdat;
    MemRead = 0; MemWrite = 1; Funct3 = 3'b010; Addr = 32'h40; WrData = $urandom;
    mif.mem_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if ({mif.mem_req, mif.mem_wstrb} !== 5'b1_1111) begin n_err++; $display("FAIL rst_busy1 got req=%b wstrb=%b want 1 1111", mif.mem_req, mif.mem_wstrb); end
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    n_cmp++; if ({mif.mem_req, mif.mem_wstrb, Stall} !== 6'b0) begin
      n_err++; $display("FAIL rst_abort got req=%b wstrb=%b stall=%b want 0 0000 0", mif.mem_req, mif.mem_wstrb, Stall);
    end
    MemWrite = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mif.mem_ack = 1'b1;
    @(posedge clk); #1;
    mif.mem_ack = 1'b0;
    @(negedge clk);
    n_cmp++; if ({mif.mem_req, Stall, Fault} !== 3'b000) begin n_err++; $display("FAIL rst_late_ack got req=%b stall=%b fault=%b want 000", mif.mem_req, Stall, Fault); end
    @(posedge clk); #1;
    rdat = $urandom;
    do_access(1, 0, 3'b010, 32'h44, 32'h0, rdat, 1);
    n_cmp++; if (ob_stall != 2) begin n_err++; $display("FAIL rst_after_stall got %0d want 2", ob_stall); end
    n_cmp++; if (ob_rd !== rdat) begin n_err++; $display("FAIL rst_after_data got %h want %h", ob_rd, rdat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rdat, wd, rd1;
    int c1;
    rdat = $urandom; wd = $urandom;
    do_access(1, 0, 3'b010, 32'h10, 32'h0, rdat, 1);
    c1 = ob_cycles; rd1 = ob_rd;
    do_access(0, 1, 3'b000, 32'h11, wd, 32'h0, 1);
    n_cmp++; if (c1 + ob_cycles != 6) begin n_err++; $display("FAIL b2b_cycles got %0d want 6", c1 + ob_cycles); end
    n_cmp++; if (rd1 !== rdat) begin n_err++; $display("FAIL b2b_lw_data got %h want %h", rd1, rdat); end
    n_cmp++; if (ob_wstrb !== 4'b0010) begin n_err++; $display("FAIL b2b_sb_wstrb got %b want 0010", ob_wstrb); end
    n_cmp++; if (ob_wdata !== m_wdata(3'b000, wd)) begin n_err++; $display("FAIL b2b_sb_wdata got %h want %h", ob_wdata, m_wdata(3'b000, wd)); end
    n_cmp++; if (ob_rd !== rdat) begin n_err++; $display("FAIL b2b_hold_data got %h want %h", ob_rd, rdat); end
    n_cmp++; if (ob_stall != 2) begin n_err++; $display("FAIL b2b_sb_stall got %0d want 2", ob_stall); end
  endtask

  task automatic test_random();
    logic [31:0] model_rd, a, wd, rdat, exp;
    logic        known, rd, wr;
    logic [2:0]  f3;
    int          k, ack_at;
    known = 1'b0; model_rd = '0;
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 9);
      rd = (k <= 5); wr = (k == 0) || (k >= 6);
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      wd = $urandom; rdat = $urandom;
      ack_at = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
      if (!m_legal(rd, wr, f3, a)) begin
        MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WrData = wd;
        @(negedge clk);
        n_cmp++; if ({Fault, Stall, mif.mem_req, ReadData} !== {3'b100, 32'd0}) begin
          n_err++; $display("FAIL rnd%0d_illegal f3=%0d a=%h got fault=%b stall=%b req=%b rd=%h want 1 0 0 0",
                            i, f3, a, Fault, Stall, mif.mem_req, ReadData);
        end
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        known = 1'b0;
      end else begin
        do_access(rd, wr, f3, a, wd, rdat, ack_at);
        n_cmp++; if ({ob_addr, ob_we} !== {a & 32'hFFFF_FFFC, wr}) begin
          n_err++; $display("FAIL rnd%0d_addr_we got %h/%b want %h/%b", i, ob_addr, ob_we, a & 32'hFFFF_FFFC, wr);
        end
        if (ack_at == 0) begin
          n_cmp++; if ({ob_stall, ob_fault, ob_rd} !== {TIMEOUT + 1, 1'b1, 32'd0}) begin
            n_err++; $display("FAIL rnd%0d_timeout got stall=%0d fault=%b rd=%h want %0d 1 0", i, ob_stall, ob_fault, ob_rd, TIMEOUT + 1);
          end
          model_rd = 32'd0; known = 1'b1;
        end else begin
          n_cmp++; if ({ob_stall, ob_fault, ob_stable} !== {ack_at + 1, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL rnd%0d_timing got stall=%0d fault=%b stable=%b want %0d 0 1", i, ob_stall, ob_fault, ob_stable, ack_at + 1);
          end
          if (rd) begin
            exp = m_load(f3, a, rdat);
            n_cmp++; if (ob_rd !== exp) begin n_err++; $display("FAIL rnd%0d_load f3=%0d a=%h got %h want %h", i, f3, a, ob_rd, exp); end
            model_rd = exp; known = 1'b1;
          end else begin
            n_cmp++; if ({ob_wdata, ob_wstrb} !== {m_wdata(f3, wd), m_wstrb(f3, a)}) begin
              n_err++; $display("FAIL rnd%0d_store f3=%0d a=%h got %h/%b want %h/%b", i, f3, a, ob_wdata, ob_wstrb, m_wdata(f3, wd), m_wstrb(f3, a));
            end
            if (known) begin
              n_cmp++; if (ob_rd !== model_rd) begin n_err++; $display("FAIL rnd%0d_hold got %h want %h", i, ob_rd, model_rd); end
            end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_illegal();
    test_timeout();
    test_reset_mid_busy();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of BUSY cycles to wait for mem_ack (range 2..255).
REQ-002 SHALL have port clk  in  1  system clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports MemRead / MemWrite  in  1 each  load/store request from the controller; both high at once is illegal.
REQ-005 SHALL have port Funct3  in  3  access size/sign, Instr[14:12].
REQ-006 SHALL have port Addr  in  32  byte address (datapath ALU result).
REQ-007 SHALL have port WrData  in  32  store data (rs2 value).
REQ-008 SHALL have port ReadData  out  32  formatted load result, fed to the result mux.
REQ-009 SHALL have port Stall  out  1  high to hold PC and suppress register write.
REQ-010 SHALL have port Fault  out  1  misaligned, illegal-Funct3 or timeout indication.
REQ-011 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 32 (word-aligned), mem_wdata out 32, mem_wstrb out 4, mem_ack in 1, mem_rdata in 32.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 In IDLE, a valid access (MemRead or MemWrite, legal Funct3, aligned Addr) SHALL drive Stall=1 combinationally and latch mem_addr={Addr[31:2],2'b00}, mem_we, mem_wdata, mem_wstrb, Funct3 and Addr[1:0], then enter BUSY.
REQ-014 In BUSY: mem_req=1; all latched mem_* outputs held stable; Stall=1; cycle counter increments from 0.
REQ-015 On mem_ack=1 in BUSY, SHALL register formatted mem_rdata into ReadData (loads only) and enter DONE.
REQ-016 If counter reaches TIMEOUT-1 without mem_ack, SHALL enter DONE with ReadData=0 and the fault flag set.
REQ-017 In DONE: Stall=0; mem_req=0; Fault=registered fault flag; MemRead/MemWrite ignored; next state IDLE unconditionally.
REQ-018 Minimum access latency SHALL be 3 cycles (IDLE, BUSY with ack, DONE); Stall is high for exactly the IDLE and BUSY cycles.
REQ-019 Load formatting: 000 LB sign-extend byte Addr[1:0]; 001 LH sign-extend half Addr[1]; 010 LW whole word; 100 LBU / 101 LHU zero-extend.
REQ-020 Store lanes: SB wdata={4{WrData[7:0]}}, wstrb=4'b0001<<Addr[1:0]; SH wdata={2{WrData[15:0]}}, wstrb 0011 (Addr[1]=0) or 1100; SW wstrb 1111.
REQ-021 Misalignment: LH/LHU/SH with Addr[0]=1, LW/SW with Addr[1:0]!=0.
REQ-022 Illegal Funct3: 011, 110, 111 for loads; any Funct3 other than 000/001/010 for stores.
REQ-023 A misaligned or illegal access in IDLE SHALL assert Fault=1 combinationally, Stall=0, ReadData=0, issue no mem_req, and remain in IDLE.
REQ-024 MemRead and MemWrite both high SHALL be treated as illegal (REQ-023 behaviour).
REQ-025 With no access in IDLE: Stall=0, Fault=0, mem_req=0, ReadData holds its last value.
REQ-026 mem_ack outside BUSY SHALL be ignored.

Reset
REQ-027 reset low SHALL immediately force state IDLE, counter 0, ReadData=0, fault flag 0, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0.
REQ-028 reset asserted mid-BUSY SHALL abort the transaction with no DONE cycle; after release, the unit re-evaluates inputs in IDLE.

Verification
REQ-029 LB at Addr=0x103, mem_rdata=0x80FF_1234, ack on first BUSY cycle -> DONE with ReadData=0xFFFF_FF80, mem_addr=0x100, Stall high for exactly 2 cycles.
REQ-030 SH at Addr=0x202, WrData=0x0000_ABCD -> mem_wdata=0xABCD_ABCD, mem_wstrb=1100, mem_we=1; ack after 3 BUSY cycles -> Stall high for 4 cycles.
REQ-031 LW at Addr=0x105 -> Fault=1, Stall=0, mem_req never asserted, ReadData=0.
REQ-032 LHU at Addr=0x0, mem_ack withheld, TIMEOUT=16 -> 16 BUSY cycles, then DONE with Fault=1, ReadData=0, Stall=0.
REQ-033 reset pulsed low during the 2nd BUSY cycle of an SW -> mem_req, mem_wstrb and Stall drop immediately; a late mem_ack after release produces no DONE.
REQ-034 Back-to-back LW 0x10 then SB 0x11 with immediate acks -> 6 cycles total, second request issued the cycle after the first DONE.
